usb_tx_arbiter: RTL and testbench
=================================

# usb_tx_arbiter

Transaction scheduler in front of the USB transmit control unit. It arbitrates between the encrypted-data requester and the handshake requester, and sequences each granted transaction into packets:
- a data transaction is an OUT token followed by a DATA0/DATA1 packet;
- a handshake transaction is a single ACK or NAK packet.

For each packet it issues a start pulse with the PID and packet kind, waits for completion, and enforces the inter-packet gap.

## Interface
Parameters:
- IPG_CYCLES, 16, idle cycles enforced after every packet (range 1..255)
- MAX_HS_STREAK, 4, consecutive handshake grants allowed while data is waiting (range 1..15)
- TIMEOUT_CYCLES, 1024, completion watchdog limit; only used with TX_ARB_TIMEOUT_EN (range 2..65535)

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  asynchronous active-low reset
- req_data  in  1  data transaction request (level)
- req_hs  in  1  handshake transaction request (level)
- hs_nak  in  1  sampled at handshake grant: 1 = NAK, 0 = ACK
- tx_done  in  1  one-cycle pulse from the transmitter when a packet's EOP completes
- err_clr  in  1  clears err_timeout
- grant_data  out  1  one-cycle pulse: data transaction accepted
- grant_hs  out  1  one-cycle pulse: handshake transaction accepted
- tx_start  out  1  one-cycle pulse: begin the packet described by tx_pid/tx_kind
- tx_pid  out  8  PID byte {~pid[3:0], pid[3:0]}
- tx_kind  out  2  00 token (CRC5), 01 data (payload + CRC16), 10 handshake
- tx_abort  out  1  one-cycle pulse: watchdog expired, transmitter must return to idle
- xact_done  out  1  one-cycle pulse at the end of every transaction
- xact_err  out  1  qualifies xact_done: transaction was aborted
- err_timeout  out  1  sticky watchdog flag
- busy  out  1  high in every state except IDLE

## Operation
PID bytes:
- OUT = 8'hE1
- DATA0 = 8'hC3
- DATA1 = 8'h4B
- ACK = 8'hD2
- NAK = 8'h5A

State machine:
- IDLE: if either request is high, go to START_TOK (data wins) or START_HS (handshake wins).
- START_TOK: tx_start, tx_kind=00, tx_pid=OUT, grant_data. Next: WAIT_TOK.
- WAIT_TOK: on tx_done, go to GAP_TOK.
- GAP_TOK: after IPG_CYCLES cycles, go to START_DAT.
- START_DAT: tx_start, tx_kind=01, tx_pid=DATA0 if toggle=0, else DATA1. Next: WAIT_DAT.
- WAIT_DAT: on tx_done, flip toggle, pulse xact_done, go to GAP.
- START_HS: tx_start, tx_kind=10, tx_pid=NAK if hs_nak, else ACK; grant_hs. Next: WAIT_HS.
- WAIT_HS: on tx_done, pulse xact_done, go to GAP.
- GAP: after IPG_CYCLES cycles, go to IDLE.

Arbitration (evaluated in IDLE only):
- Handshake wins unless hs_streak == MAX_HS_STREAK and req_data is high; then data wins.
- hs_streak (4 bits) increments on each grant_hs, saturates at MAX_HS_STREAK, and clears on grant_data.

Requests:
- A requester must drop its request the cycle after its grant.
- Requests are ignored outside IDLE.

Packet outputs:
- tx_pid and tx_kind are registered.
- They are valid from the START cycle and held stable until the next START.

tx_done handling:
- tx_done is ignored outside WAIT_* states.

## Timing
- Reset values: all pulse outputs 0, tx_pid=8'h00, tx_kind=2'b00, err_timeout=0, xact_err=0, busy=0, toggle=0, hs_streak=0, state IDLE, all counters 0.
- Request-to-start latency: request high in IDLE at cycle N gives grant and tx_start at cycle N+1.
- tx_done at cycle M in WAIT gives GAP from M+1. The next START, or return to IDLE, occurs at M+1+IPG_CYCLES.
- The gap counter reloads on every GAP entry.
- Minimum handshake transaction: 1 (START) + wait + IPG_CYCLES cycles.
- Reset mid-transaction: outputs return to reset values immediately. No xact_done is generated. The toggle resets to DATA0.
- tx_done coincident with watchdog expiry: tx_done wins and no abort is raised.
- err_clr in the same cycle as a new timeout: the set wins.

## Configuration
- TX_ARB_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles spent in WAIT_TOK, WAIT_DAT and WAIT_HS, and clears on every START.
  - When the count reaches TIMEOUT_CYCLES without tx_done: pulse tx_abort, set err_timeout, pulse xact_done with xact_err=1, go to GAP.
  - The toggle is not flipped.
  - An abort in WAIT_TOK skips the data packet.
- TX_ARB_TIMEOUT_EN undefined:
  - WAIT states wait indefinitely.
  - tx_abort, err_timeout and xact_err are tied to 0.
  - err_clr is unused.

## Test plan
- req_data pulse, tx_done 5 cycles after each tx_start, IPG_CYCLES=16 -> tx_start with E1/00, then 16 gap cycles, then tx_start with C3/01; xact_done once; the next data transaction uses 4B.
- req_hs with hs_nak=1 -> grant_hs and tx_start with 5A/10 one cycle after the request; no grant_data.
- req_hs and req_data held continuously, MAX_HS_STREAK=4 -> grant order is hs, hs, hs, hs, data, then repeats.
- TX_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=32, tx_done never sent after the token -> tx_abort 32 cycles after the WAIT_TOK entry; xact_err=1; err_timeout stays 1 until err_clr; no DATA packet; toggle unchanged.
- n_rst asserted during WAIT_DAT after one completed DATA0 transaction -> all outputs at reset values; the next data transaction sends C3.
- tx_done asserted in IDLE and GAP -> no state change and no xact_done.

Source files
------------

// File: rtl/usb_tx_arbiter.sv
// USB transmit transaction scheduler: arbitrates data vs handshake requests and sequences packets.
// Optional completion watchdog enabled by defining TX_ARB_TIMEOUT_EN.
module usb_tx_arbiter #(
    parameter int IPG_CYCLES     = 16,
    parameter int MAX_HS_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       req_data,
    input  logic       req_hs,
    input  logic       hs_nak,
    input  logic       tx_done,
    input  logic       err_clr,
    output logic       grant_data,
    output logic       grant_hs,
    output logic       tx_start,
    output logic [7:0] tx_pid,
    output logic [1:0] tx_kind,
    output logic       tx_abort,
    output logic       xact_done,
    output logic       xact_err,
    output logic       err_timeout,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_TOK = 4'd1,
        ST_WAIT_TOK  = 4'd2,
        ST_GAP_TOK   = 4'd3,
        ST_START_DAT = 4'd4,
        ST_WAIT_DAT  = 4'd5,
        ST_START_HS  = 4'd6,
        ST_WAIT_HS   = 4'd7,
        ST_GAP       = 4'd8
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;

    localparam logic [1:0] KIND_TOKEN = 2'b00;
    localparam logic [1:0] KIND_DATA  = 2'b01;
    localparam logic [1:0] KIND_HS    = 2'b10;

    localparam logic [7:0] GAP_LAST = 8'(IPG_CYCLES - 1);
    localparam logic [3:0] HS_MAX   = 4'(MAX_HS_STREAK);

    // The upper nibble is the check field: ones' complement of the PID code.
    function automatic logic [7:0] pid_byte(input logic [3:0] code);
        return {~code, code};
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  gap_cnt_r;
    logic [3:0]  hs_streak_r;
    logic        toggle_r;
    logic        data_win_s;
    logic        gap_load_s;
    logic        done_s;
    logic        abort_s;
    logic        flip_s;
    logic        wdog_expire_s;

    logic        grant_data_r;
    logic        grant_hs_r;
    logic        tx_start_r;
    logic [7:0]  tx_pid_r;
    logic [1:0]  tx_kind_r;
    logic        xact_done_r;
    logic        busy_r;

    assign data_win_s = req_data && (!req_hs || (hs_streak_r == HS_MAX));

    // Next-state decode; completion always takes priority over watchdog expiry.
    always_comb begin
        state_nxt_s = state_r;
        gap_load_s  = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        flip_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data_win_s) begin
                    state_nxt_s = ST_START_TOK;
                end else if (req_hs) begin
                    state_nxt_s = ST_START_HS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START_TOK: state_nxt_s = ST_WAIT_TOK;
            ST_WAIT_TOK: begin
                if (tx_done) begin
                    state_nxt_s = ST_GAP_TOK;
                    gap_load_s  = 1'b1;
                end else if (wdog_expire_s) begin
                    state_nxt_s = ST_GAP;
                    gap_load_s  = 1'b1;
                    done_s      = 1'b1;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_TOK;
                end
            end
            ST_GAP_TOK: begin
                if (gap_cnt_r == 8'd0) begin
                    state_nxt_s = ST_START_DAT;
                end else begin
                    state_nxt_s = ST_GAP_TOK;
                end
            end
            ST_START_DAT: state_nxt_s = ST_WAIT_DAT;
            ST_WAIT_DAT: begin
                if (tx_done) begin
                    state_nxt_s = ST_GAP;
                    gap_load_s  = 1'b1;
                    done_s      = 1'b1;
                    flip_s      = 1'b1;
                end else if (wdog_expire_s) begin
                    state_nxt_s = ST_GAP;
                    gap_load_s  = 1'b1;
                    done_s      = 1'b1;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_DAT;
                end
            end
            ST_START_HS: state_nxt_s = ST_WAIT_HS;
            ST_WAIT_HS: begin
                if (tx_done) begin
                    state_nxt_s = ST_GAP;
                    gap_load_s  = 1'b1;
                    done_s      = 1'b1;
                end else if (wdog_expire_s) begin
                    state_nxt_s = ST_GAP;
                    gap_load_s  = 1'b1;
                    done_s      = 1'b1;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_HS;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, gap counter, data toggle and handshake streak.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            gap_cnt_r   <= 8'd0;
            toggle_r    <= 1'b0;
            hs_streak_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (gap_load_s) begin
                gap_cnt_r <= GAP_LAST;
            end else if (gap_cnt_r != 8'd0) begin
                gap_cnt_r <= gap_cnt_r - 8'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
            if (flip_s) begin
                toggle_r <= ~toggle_r;
            end else begin
                toggle_r <= toggle_r;
            end
            if (state_nxt_s == ST_START_TOK) begin
                hs_streak_r <= 4'd0;
            end else if ((state_nxt_s == ST_START_HS) && (hs_streak_r != HS_MAX)) begin
                hs_streak_r <= hs_streak_r + 4'd1;
            end else begin
                hs_streak_r <= hs_streak_r;
            end
        end
    end

    // Registered packet and transaction outputs, decoded from the next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant_data_r <= 1'b0;
            grant_hs_r   <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_pid_r     <= 8'h00;
            tx_kind_r    <= 2'b00;
            xact_done_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            grant_data_r <= (state_nxt_s == ST_START_TOK);
            grant_hs_r   <= (state_nxt_s == ST_START_HS);
            tx_start_r   <= (state_nxt_s == ST_START_TOK) || (state_nxt_s == ST_START_DAT) ||
                            (state_nxt_s == ST_START_HS);
            xact_done_r  <= done_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            case (state_nxt_s)
                ST_START_TOK: begin
                    tx_pid_r  <= pid_byte(PID_OUT);
                    tx_kind_r <= KIND_TOKEN;
                end
                ST_START_DAT: begin
                    tx_pid_r  <= toggle_r ? pid_byte(PID_DATA1) : pid_byte(PID_DATA0);
                    tx_kind_r <= KIND_DATA;
                end
                ST_START_HS: begin
                    tx_pid_r  <= hs_nak ? pid_byte(PID_NAK) : pid_byte(PID_ACK);
                    tx_kind_r <= KIND_HS;
                end
                default: begin
                    tx_pid_r  <= tx_pid_r;
                    tx_kind_r <= tx_kind_r;
                end
            endcase
        end
    end

    assign grant_data = grant_data_r;
    assign grant_hs   = grant_hs_r;
    assign tx_start   = tx_start_r;
    assign tx_pid     = tx_pid_r;
    assign tx_kind    = tx_kind_r;
    assign xact_done  = xact_done_r;
    assign busy       = busy_r;

`ifdef TX_ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog_cnt_r;
    logic        tx_abort_r;
    logic        xact_err_r;
    logic        err_timeout_r;
    logic        in_wait_s;
    logic        in_start_s;

    assign in_wait_s     = (state_r == ST_WAIT_TOK) || (state_r == ST_WAIT_DAT) ||
                           (state_r == ST_WAIT_HS);
    assign in_start_s    = (state_r == ST_START_TOK) || (state_r == ST_START_DAT) ||
                           (state_r == ST_START_HS);
    assign wdog_expire_s = in_wait_s && (wdog_cnt_r == WDOG_LAST);

    // Watchdog counter and abort/error flags; a new timeout beats err_clr.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdog_cnt_r    <= 16'd0;
            tx_abort_r    <= 1'b0;
            xact_err_r    <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            if (in_start_s) begin
                wdog_cnt_r <= 16'd0;
            end else if (in_wait_s) begin
                wdog_cnt_r <= wdog_cnt_r + 16'd1;
            end else begin
                wdog_cnt_r <= wdog_cnt_r;
            end
            tx_abort_r <= abort_s;
            xact_err_r <= abort_s;
            if (abort_s) begin
                err_timeout_r <= 1'b1;
            end else if (err_clr) begin
                err_timeout_r <= 1'b0;
            end else begin
                err_timeout_r <= err_timeout_r;
            end
        end
    end

    assign tx_abort    = tx_abort_r;
    assign xact_err    = xact_err_r;
    assign err_timeout = err_timeout_r;
`else
    logic unused_wdog_s;

    assign wdog_expire_s = 1'b0;
    assign unused_wdog_s = err_clr ^ abort_s;
    assign tx_abort      = 1'b0;
    assign xact_err      = 1'b0;
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter with hand-computed expectations.
// Timeout scenarios are built only when TX_ARB_TIMEOUT_EN is defined.
module tb_usb_tx_arbiter;

    logic       clk;
    logic       n_rst;
    logic       req_data;
    logic       req_hs;
    logic       hs_nak;
    logic       tx_done;
    logic       err_clr;
    logic       grant_data;
    logic       grant_hs;
    logic       tx_start;
    logic [7:0] tx_pid;
    logic [1:0] tx_kind;
    logic       tx_abort;
    logic       xact_done;
    logic       xact_err;
    logic       err_timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    usb_tx_arbiter #(
        .IPG_CYCLES     (16),
        .MAX_HS_STREAK  (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_data    (req_data),
        .req_hs      (req_hs),
        .hs_nak      (hs_nak),
        .tx_done     (tx_done),
        .err_clr     (err_clr),
        .grant_data  (grant_data),
        .grant_hs    (grant_hs),
        .tx_start    (tx_start),
        .tx_pid      (tx_pid),
        .tx_kind     (tx_kind),
        .tx_abort    (tx_abort),
        .xact_done   (xact_done),
        .xact_err    (xact_err),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        req_data = 1'b0; req_hs = 1'b0; hs_nak = 1'b0; tx_done = 1'b0; err_clr = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        req_data = 1'b0; req_hs = 1'b0; hs_nak = 1'b0; tx_done = 1'b0; err_clr = 1'b0;
        repeat (2) tick();
        checks++;
        if ({grant_data, grant_hs, tx_start, tx_abort, xact_done} !== 5'b00000) begin
            errors++; $display("FAIL reset_pulses got %b want 00000", {grant_data, grant_hs, tx_start, tx_abort, xact_done});
        end
        checks++;
        if ({tx_pid, tx_kind} !== {8'h00, 2'b00}) begin
            errors++; $display("FAIL reset_pid_kind got %h/%b want 00/00", tx_pid, tx_kind);
        end
        checks++;
        if ({err_timeout, xact_err, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {err_timeout, xact_err, busy});
        end
        n_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%b start=%b want 0 0", busy, tx_start);
        end
    endtask

    // One data transaction: tx_done 5 cycles after each tx_start, 16-cycle gaps.
    task automatic run_data(input logic [7:0] exp_pid);
        int   nd;
        logic gap_bad;
        nd = 0;
        gap_bad = 1'b0;
        req_data = 1'b1;
        tick();
        req_data = 1'b0;
        checks++;
        if (tx_start !== 1'b1 || grant_data !== 1'b1 || grant_hs !== 1'b0) begin
            errors++; $display("FAIL data_grant start=%b gd=%b gh=%b want 1 1 0", tx_start, grant_data, grant_hs);
        end
        checks++;
        if ({tx_pid, tx_kind} !== {8'hE1, 2'b00}) begin
            errors++; $display("FAIL token_pid got %h/%b want e1/00", tx_pid, tx_kind);
        end
        repeat (4) begin tick(); nd += int'(xact_done); end
        tick(); tx_done = 1'b1; nd += int'(xact_done);
        tick(); tx_done = 1'b0; nd += int'(xact_done);
        if (tx_start !== 1'b0 || tx_pid !== 8'hE1) gap_bad = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick(); nd += int'(xact_done);
            if (tx_start !== 1'b0 || tx_pid !== 8'hE1) gap_bad = 1'b1;
        end
        checks++;
        if (gap_bad !== 1'b0) begin
            errors++; $display("FAIL token_gap got early start or pid change, want quiet 16-cycle gap");
        end
        tick(); nd += int'(xact_done);
        checks++;
        if (tx_start !== 1'b1 || {tx_pid, tx_kind} !== {exp_pid, 2'b01} || grant_data !== 1'b0) begin
            errors++; $display("FAIL data_start start=%b pid=%h kind=%b gd=%b want 1 %h 01 0", tx_start, tx_pid, tx_kind, grant_data, exp_pid);
        end
        repeat (4) begin tick(); nd += int'(xact_done); end
        tick(); tx_done = 1'b1; nd += int'(xact_done);
        tick(); tx_done = 1'b0; nd += int'(xact_done);
        repeat (15) begin tick(); nd += int'(xact_done); end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL data_gap_end busy got %b want 1", busy);
        end
        tick(); nd += int'(xact_done);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL data_idle busy got %b want 0", busy);
        end
        checks++;
        if (nd !== 1) begin
            errors++; $display("FAIL data_xact_done count got %0d want 1", nd);
        end
    endtask

    task automatic run_hs(input logic nak, input logic [7:0] exp_pid);
        int nd;
        nd = 0;
        hs_nak = nak;
        req_hs = 1'b1;
        tick();
        req_hs = 1'b0;
        checks++;
        if (grant_hs !== 1'b1 || tx_start !== 1'b1 || grant_data !== 1'b0) begin
            errors++; $display("FAIL hs_grant gh=%b start=%b gd=%b want 1 1 0", grant_hs, tx_start, grant_data);
        end
        checks++;
        if ({tx_pid, tx_kind} !== {exp_pid, 2'b10}) begin
            errors++; $display("FAIL hs_pid got %h/%b want %h/10", tx_pid, tx_kind, exp_pid);
        end
        hs_nak = 1'b0;
        repeat (2) begin tick(); nd += int'(xact_done); end
        tick(); tx_done = 1'b1; nd += int'(xact_done);
        tick(); tx_done = 1'b0; nd += int'(xact_done);
        repeat (15) begin tick(); nd += int'(xact_done); end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL hs_gap_end busy got %b want 1", busy);
        end
        tick(); nd += int'(xact_done);
        checks++;
        if (busy !== 1'b0 || nd !== 1) begin
            errors++; $display("FAIL hs_done busy=%b xact_done_count=%0d want 0 1", busy, nd);
        end
    endtask

    task automatic test_data();
        run_data(8'hC3);
        run_data(8'h4B);
        run_data(8'hC3);
    endtask

    task automatic test_hs();
        run_hs(1'b1, 8'h5A);
        run_hs(1'b0, 8'hD2);
    endtask

    task automatic test_tx_done_ignored();
        int nd;
        nd = 0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (3) begin tick(); nd += int'(xact_done); end
        checks++;
        if (busy !== 1'b0 || nd !== 0) begin
            errors++; $display("FAIL idle_tx_done busy=%b xact_done_count=%0d want 0 0", busy, nd);
        end
        hs_nak = 1'b1;
        req_hs = 1'b1;
        tick();
        req_hs = 1'b0;
        hs_nak = 1'b0;
        tick(); tx_done = 1'b1; nd += int'(xact_done);
        tick(); tx_done = 1'b0; nd += int'(xact_done);
        repeat (3) begin tick(); nd += int'(xact_done); end
        tx_done = 1'b1;
        tick(); tx_done = 1'b0; nd += int'(xact_done);
        repeat (11) begin tick(); nd += int'(xact_done); end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL gap_tx_done busy got %b want 1 at gap end", busy);
        end
        tick(); nd += int'(xact_done);
        checks++;
        if (busy !== 1'b0 || nd !== 1) begin
            errors++; $display("FAIL gap_tx_done_idle busy=%b xact_done_count=%0d want 0 1", busy, nd);
        end
    endtask

    task automatic test_streak();
        logic order [10];
        logic expv  [10];
        int   ng;
        int   dcnt;
        logic done_ok;
        apply_reset();
        for (int i = 0; i < 10; i++) expv[i] = ((i % 5) == 4) ? 1'b1 : 1'b0;
        ng = 0;
        dcnt = -1;
        done_ok = 1'b0;
        req_hs = 1'b1;
        req_data = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            tx_done = 1'b0;
            if (grant_hs === 1'b1 && ng < 10) begin order[ng] = 1'b0; ng++; end
            if (grant_data === 1'b1 && ng < 10) begin order[ng] = 1'b1; ng++; end
            if (ng >= 10) begin req_hs = 1'b0; req_data = 1'b0; end
            if (tx_start === 1'b1) dcnt = 2;
            else if (dcnt > 0) dcnt--;
            if (dcnt == 0) begin tx_done = 1'b1; dcnt = -1; end
            if (ng >= 10 && busy === 1'b0) begin done_ok = 1'b1; break; end
        end
        req_hs = 1'b0;
        req_data = 1'b0;
        tx_done = 1'b0;
        checks++;
        if (done_ok !== 1'b1) begin
            errors++; $display("FAIL streak_timeout grants=%0d want 10 and idle", ng);
        end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (order[i] !== expv[i]) begin
                errors++; $display("FAIL streak_order[%0d] got %s want %s", i, order[i] ? "data" : "hs", expv[i] ? "data" : "hs");
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_data(8'hC3);
        req_data = 1'b1;
        tick();
        req_data = 1'b0;
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (16) tick();
        checks++;
        if (tx_start !== 1'b1 || tx_pid !== 8'h4B) begin
            errors++; $display("FAIL mid_data_start start=%b pid=%h want 1 4b", tx_start, tx_pid);
        end
        repeat (2) tick();
        n_rst = 1'b0;
        #1;
        checks++;
        if ({tx_pid, tx_kind, busy, tx_start, xact_done, grant_data} !== {8'h00, 2'b00, 4'b0000}) begin
            errors++; $display("FAIL mid_reset_outputs pid=%h kind=%b busy=%b start=%b done=%b want 00 00 0 0 0", tx_pid, tx_kind, busy, tx_start, xact_done);
        end
        tick();
        n_rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (xact_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_quiet done=%b busy=%b want 0 0", xact_done, busy);
        end
        run_data(8'hC3);
    endtask

`ifdef TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic early;
        logic stray;
        apply_reset();
        early = 1'b0;
        stray = 1'b0;
        req_data = 1'b1;
        tick();
        req_data = 1'b0;
        for (int k = 1; k < 33; k++) begin
            tick();
            if (tx_abort !== 1'b0 || xact_done !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL abort_early got abort/done before 32 wait cycles, want none");
        end
        tick();
        checks++;
        if ({tx_abort, xact_done, xact_err, err_timeout} !== 4'b1111) begin
            errors++; $display("FAIL abort_pulse got %b want 1111", {tx_abort, xact_done, xact_err, err_timeout});
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (tx_start !== 1'b0 || err_timeout !== 1'b1 || tx_abort !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_after stray=%b busy=%b want 0 0", stray, busy);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL err_clr got %b want 0", err_timeout);
        end
        run_data(8'hC3);
    endtask
`else
    task automatic test_timeout();
        logic bad;
        int   waited;
        apply_reset();
        bad = 1'b0;
        req_data = 1'b1;
        tick();
        req_data = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (busy !== 1'b1 || tx_abort !== 1'b0 || xact_done !== 1'b0 || err_timeout !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL wait_forever got abort or exit, want busy with no abort");
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        waited = 0;
        while (tx_start !== 1'b1 && waited < 40) begin tick(); waited++; end
        checks++;
        if (waited !== 16 || tx_pid !== 8'hC3) begin
            errors++; $display("FAIL late_data_start cycles=%0d pid=%h want 16 c3", waited, tx_pid);
        end
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        waited = 0;
        while (busy !== 1'b0 && waited < 40) begin tick(); waited++; end
        checks++;
        if (busy !== 1'b0 || xact_err !== 1'b0) begin
            errors++; $display("FAIL late_idle busy=%b err=%b want 0 0", busy, xact_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_data();
        test_hs();
        test_tx_done_ignored();
        test_streak();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
